insertion_sort_ctrl: RTL and testbench



---
 rtl/insertion_sort_pkg.sv | 50 +++++
 rtl/insertion_sort_wr_join.sv | 54 +++++
 rtl/insertion_sort_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_insertion_sort_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insertion_sort_pkg.sv
// rtl/insertion_sort_pkg.sv - shared state encoding, select encodings and response codes for the insertion sorter
package insertion_sort_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT_I, S_CHK_I,
    S_KEY_ADDR, S_KEY_AR, S_KEY_R, S_KEY_LD,
    S_CHK_J,
    S_CMP_ADDR, S_CMP_AR, S_CMP_R, S_CMP_LD, S_CMP,
    S_SHF_ADDR, S_SHF_WR, S_DEC_J,
    S_INS_ADDR, S_INS_WR, S_INC_I,
    S_DONE
  } sort_state_e;

  // Datapath mux selects: value 0 picks the first source, 1 the second.
  localparam logic SEL_I_CONST1       = 1'b0;
  localparam logic SEL_I_INC          = 1'b1;
  localparam logic SEL_J_I_MINUS_1    = 1'b0;
  localparam logic SEL_J_DEC          = 1'b1;
  localparam logic SEL_RADDR_I        = 1'b0;
  localparam logic SEL_RADDR_J        = 1'b1;
  localparam logic SEL_WADDR_J        = 1'b0;
  localparam logic SEL_WADDR_J_PLUS_1 = 1'b1;
  localparam logic SEL_WDATA_E2I      = 1'b0;
  localparam logic SEL_WDATA_E2C      = 1'b1;

  localparam int unsigned RESP_OKAY = 0;

  // Registered controller outputs, grouped so they reset and load as one word.
  typedef struct packed {
    logic busy;
    logic done;
    logic wr_go;
    logic ar_valid;
    logic r_ready;
    logic sl_1_incd_to_i;
    logic ld_i;
    logic sl_i_minus_1_decrd_to_j;
    logic ld_j;
    logic ld_elem2insert;
    logic ld_elem2compare;
    logic sl_i_j_to_arg_read_addr;
    logic ld_arg_read_addr;
    logic ld_return_read_data;
    logic sl_j_j_plus_1_to_arg_write_addr;
    logic ld_arg_write_addr;
    logic sl_elem2insert_elem2compare_to_arg_write_data;
    logic ld_arg_write_data;
  } ctrl_out_t;

endpackage

// File: rtl/insertion_sort_wr_join.sv
// rtl/insertion_sort_wr_join.sv - issues AW and W together, retires each independently, then waits for B
module insertion_sort_wr_join (
  input  logic clk,
  input  logic rst_n,
  input  logic go_i,
  output logic aw_valid_o,
  input  logic aw_ready_i,
  output logic w_valid_o,
  input  logic w_ready_i,
  input  logic b_valid_i,
  output logic b_ready_o,
  output logic done_o
);

  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic b_ready_q, b_ready_d;

  // Each valid stays up until its own ready; B is requested once both channels have retired.
  always_comb begin
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    if (go_i) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
    end else begin
      if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
      if (w_valid_q && w_ready_i)   w_valid_d  = 1'b0;
      if ((aw_valid_q || w_valid_q) && !aw_valid_d && !w_valid_d) b_ready_d = 1'b1;
      if (b_ready_q && b_valid_i)   b_ready_d  = 1'b0;
    end
  end

  // Handshake state registers; reset drops every valid/ready immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
    end else begin
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
    end
  end

  assign aw_valid_o = aw_valid_q;
  assign w_valid_o  = w_valid_q;
  assign b_ready_o  = b_ready_q;
  // Internal completion strobe: the write is finished on the B handshake cycle.
  assign done_o     = b_ready_q && b_valid_i;

endmodule

// File: rtl/insertion_sort_ctrl.sv
// rtl/insertion_sort_ctrl.sv - insertion-sort sequencer; INSERTION_SORT_CTRL_PERF_EN adds cyc_cnt/wr_cnt
module insertion_sort_ctrl
  import insertion_sort_pkg::*;
#(
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
`ifdef INSERTION_SORT_CTRL_PERF_EN
  output logic [31:0]          cyc_cnt,
  output logic [15:0]          wr_cnt,
`endif
  input  logic                 elem2insert_gt_elem2compare,
  input  logic                 j_gte_0,
  input  logic                 i_lt_arr_size,
  output logic                 sl_1_incd_to_i,
  output logic                 ld_i,
  output logic                 sl_i_minus_1_decrd_to_j,
  output logic                 ld_j,
  output logic                 ld_elem2insert,
  output logic                 ld_elem2compare,
  output logic                 sl_i_j_to_arg_read_addr,
  output logic                 ld_arg_read_addr,
  output logic                 ld_return_read_data,
  output logic                 sl_j_j_plus_1_to_arg_write_addr,
  output logic                 ld_arg_write_addr,
  output logic                 sl_elem2insert_elem2compare_to_arg_write_data,
  output logic                 ld_arg_write_data,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic                 r_valid,
  output logic                 r_ready,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic                 w_valid,
  input  logic                 w_ready,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  sort_state_e state_q, state_d;
  ctrl_out_t   out_q, out_d;
  logic        err_q, err_d;
  logic        wr_done;
  logic        start_accept;

  assign start_accept = (state_q == S_IDLE) && start;

  // Next state, plus Moore outputs decoded from the next state so they are registered yet aligned to it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_INIT_I;
      S_INIT_I:   state_d = S_CHK_I;
      S_CHK_I:    state_d = i_lt_arr_size ? S_KEY_ADDR : S_DONE;
      S_KEY_ADDR: state_d = S_KEY_AR;
      S_KEY_AR:   if (ar_ready) state_d = S_KEY_R;
      S_KEY_R:    if (r_valid) state_d = S_KEY_LD;
      S_KEY_LD:   state_d = S_CHK_J;
      S_CHK_J:    state_d = j_gte_0 ? S_CMP_ADDR : S_INS_ADDR;
      S_CMP_ADDR: state_d = S_CMP_AR;
      S_CMP_AR:   if (ar_ready) state_d = S_CMP_R;
      S_CMP_R:    if (r_valid) state_d = S_CMP_LD;
      S_CMP_LD:   state_d = S_CMP;
      // Equal keys take the shift path, so the sort is not stable.
      S_CMP:      state_d = elem2insert_gt_elem2compare ? S_INS_ADDR : S_SHF_ADDR;
      S_SHF_ADDR: state_d = S_SHF_WR;
      S_SHF_WR:   if (wr_done) state_d = S_DEC_J;
      S_DEC_J:    state_d = S_CHK_J;
      S_INS_ADDR: state_d = S_INS_WR;
      S_INS_WR:   if (wr_done) state_d = S_INC_I;
      S_INC_I:    state_d = S_CHK_I;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    out_d = '0;
    out_d.sl_1_incd_to_i                               = SEL_I_CONST1;
    out_d.sl_i_minus_1_decrd_to_j                      = SEL_J_I_MINUS_1;
    out_d.sl_i_j_to_arg_read_addr                      = SEL_RADDR_I;
    out_d.sl_j_j_plus_1_to_arg_write_addr              = SEL_WADDR_J;
    out_d.sl_elem2insert_elem2compare_to_arg_write_data = SEL_WDATA_E2I;
    out_d.busy = (state_d != S_IDLE) && (state_d != S_DONE);
    unique case (state_d)
      S_INIT_I: out_d.ld_i = 1'b1;
      S_KEY_ADDR: out_d.ld_arg_read_addr = 1'b1;
      S_CMP_ADDR: begin
        out_d.ld_arg_read_addr        = 1'b1;
        out_d.sl_i_j_to_arg_read_addr = SEL_RADDR_J;
      end
      S_KEY_AR, S_CMP_AR: out_d.ar_valid = 1'b1;
      // The datapath latches read data every cycle of the R wait; the last latch is the handshake beat.
      S_KEY_R, S_CMP_R: begin
        out_d.r_ready             = 1'b1;
        out_d.ld_return_read_data = 1'b1;
      end
      S_KEY_LD: begin
        out_d.ld_elem2insert = 1'b1;
        out_d.ld_j           = 1'b1;
      end
      S_CMP_LD: out_d.ld_elem2compare = 1'b1;
      S_SHF_ADDR: begin
        out_d.ld_arg_write_addr                             = 1'b1;
        out_d.sl_j_j_plus_1_to_arg_write_addr               = SEL_WADDR_J_PLUS_1;
        out_d.ld_arg_write_data                             = 1'b1;
        out_d.sl_elem2insert_elem2compare_to_arg_write_data = SEL_WDATA_E2C;
      end
      S_INS_ADDR: begin
        out_d.ld_arg_write_addr               = 1'b1;
        out_d.sl_j_j_plus_1_to_arg_write_addr = SEL_WADDR_J_PLUS_1;
        out_d.ld_arg_write_data               = 1'b1;
      end
      S_SHF_WR, S_INS_WR: out_d.wr_go = (state_q != state_d);
      S_DEC_J: begin
        out_d.ld_j                    = 1'b1;
        out_d.sl_i_minus_1_decrd_to_j = SEL_J_DEC;
      end
      S_INC_I: begin
        out_d.ld_i           = 1'b1;
        out_d.sl_1_incd_to_i = SEL_I_INC;
      end
      S_DONE: out_d.done = 1'b1;
      default: ;
    endcase

    err_d = err_q;
    if (start_accept) err_d = 1'b0;
    else if (b_valid && b_ready && (b_resp != RESP_WDTH'(RESP_OKAY))) err_d = 1'b1;
  end

  // State, output and sticky-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  insertion_sort_wr_join u_wr_join (
    .clk        (clk),
    .rst_n      (rst_n),
    .go_i       (out_q.wr_go),
    .aw_valid_o (aw_valid),
    .aw_ready_i (aw_ready),
    .w_valid_o  (w_valid),
    .w_ready_i  (w_ready),
    .b_valid_i  (b_valid),
    .b_ready_o  (b_ready),
    .done_o     (wr_done)
  );

  assign busy                            = out_q.busy;
  assign done                            = out_q.done;
  assign err                             = err_q;
  assign ar_valid                        = out_q.ar_valid;
  assign r_ready                         = out_q.r_ready;
  assign sl_1_incd_to_i                  = out_q.sl_1_incd_to_i;
  assign ld_i                            = out_q.ld_i;
  assign sl_i_minus_1_decrd_to_j         = out_q.sl_i_minus_1_decrd_to_j;
  assign ld_j                            = out_q.ld_j;
  assign ld_elem2insert                  = out_q.ld_elem2insert;
  assign ld_elem2compare                 = out_q.ld_elem2compare;
  assign sl_i_j_to_arg_read_addr         = out_q.sl_i_j_to_arg_read_addr;
  assign ld_arg_read_addr                = out_q.ld_arg_read_addr;
  assign ld_return_read_data             = out_q.ld_return_read_data;
  assign sl_j_j_plus_1_to_arg_write_addr = out_q.sl_j_j_plus_1_to_arg_write_addr;
  assign ld_arg_write_addr               = out_q.ld_arg_write_addr;
  assign sl_elem2insert_elem2compare_to_arg_write_data = out_q.sl_elem2insert_elem2compare_to_arg_write_data;
  assign ld_arg_write_data               = out_q.ld_arg_write_data;

`ifdef INSERTION_SORT_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Saturating busy-cycle and completed-write counters, cleared on an accepted start.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (start_accept) begin
      cyc_cnt_d = '0;
      wr_cnt_d  = '0;
    end else begin
      if (out_q.busy && (cyc_cnt_q != '1)) cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (wr_done && (wr_cnt_q != '1))     wr_cnt_d  = wr_cnt_q + 16'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign wr_cnt  = wr_cnt_q;
`endif

endmodule

// File: tb/tb_insertion_sort_ctrl.sv
// tb/tb_insertion_sort_ctrl.sv - directed bench with datapath and array-memory models around insertion_sort_ctrl
module tb_insertion_sort_ctrl;

  logic clk = 1'b0;
  logic rst_n, start;
  logic busy, done, err;
  logic gt_flag, j_gte_0, i_lt_arr_size;
  logic sl_i, ld_i, sl_j, ld_j, ld_e2i, ld_e2c, sl_ra, ld_ra, ld_rd, sl_wa, ld_wa, sl_wd, ld_wd;
  logic ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [0:0] b_resp;
`ifdef INSERTION_SORT_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [15:0] wr_cnt;
`endif

  always #5 clk = ~clk;

  insertion_sort_ctrl #(.RESP_WDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
`ifdef INSERTION_SORT_CTRL_PERF_EN
    .cyc_cnt(cyc_cnt), .wr_cnt(wr_cnt),
`endif
    .elem2insert_gt_elem2compare(gt_flag), .j_gte_0(j_gte_0), .i_lt_arr_size(i_lt_arr_size),
    .sl_1_incd_to_i(sl_i), .ld_i(ld_i), .sl_i_minus_1_decrd_to_j(sl_j), .ld_j(ld_j),
    .ld_elem2insert(ld_e2i), .ld_elem2compare(ld_e2c),
    .sl_i_j_to_arg_read_addr(sl_ra), .ld_arg_read_addr(ld_ra), .ld_return_read_data(ld_rd),
    .sl_j_j_plus_1_to_arg_write_addr(sl_wa), .ld_arg_write_addr(ld_wa),
    .sl_elem2insert_elem2compare_to_arg_write_data(sl_wd), .ld_arg_write_data(ld_wd),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .r_valid(r_valid), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  // Bench controls, written only by the stimulus block.
  int         arr_size = 0;
  int         err_at = -1;
  logic       bp_mode = 1'b0;
  logic       mem_load = 1'b0;
  logic [7:0] init_mem [0:7];

  // Datapath and memory model state.
  int         dp_i, dp_j;
  logic [7:0] dp_e2i, dp_e2c, dp_rdq, dp_wd, rd_data, wd_cap;
  logic [2:0] dp_ra, dp_wa, wa_cap;
  logic       rd_pend, aw_got, w_got, b_pend, b_err, ar_rdy;
  int         w_wait;
  logic [7:0] mem [0:7];
  logic [2:0] wr_log [0:63];
  int         wr_total = 0;

  assign i_lt_arr_size = (dp_i < arr_size);
  assign j_gte_0       = (dp_j >= 0);
  assign gt_flag       = (dp_e2i > dp_e2c);
  assign ar_ready      = ar_rdy;
  assign aw_ready      = 1'b1;
  assign w_ready       = bp_mode ? (w_wait >= 3) : 1'b1;
  assign r_valid       = rd_pend;
  assign b_valid       = b_pend;
  assign b_resp        = b_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_i <= 0; dp_j <= 0; dp_e2i <= '0; dp_e2c <= '0; dp_rdq <= '0; dp_wd <= '0;
      dp_ra <= '0; dp_wa <= '0; rd_data <= '0; wd_cap <= '0; wa_cap <= '0;
      rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; b_err <= 1'b0;
      ar_rdy <= 1'b0; w_wait <= 0;
    end else begin
      if (mem_load) mem <= init_mem;
      if (ld_i)   dp_i   <= sl_i ? dp_i + 1 : 1;
      if (ld_j)   dp_j   <= sl_j ? dp_j - 1 : dp_i - 1;
      if (ld_e2i) dp_e2i <= dp_rdq;
      if (ld_e2c) dp_e2c <= dp_rdq;
      if (ld_ra)  dp_ra  <= sl_ra ? 3'(dp_j) : 3'(dp_i);
      if (ld_rd)  dp_rdq <= rd_data;
      if (ld_wa)  dp_wa  <= sl_wa ? 3'(dp_j + 1) : 3'(dp_j);
      if (ld_wd)  dp_wd  <= sl_wd ? dp_e2c : dp_e2i;
      ar_rdy <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar_valid && ar_ready) begin
        rd_pend <= 1'b1;
        rd_data <= mem[dp_ra];
      end else if (r_valid && r_ready) rd_pend <= 1'b0;
      if (aw_valid && aw_ready) begin
        aw_got <= 1'b1;
        wa_cap <= dp_wa;
      end
      if (w_valid && w_ready) begin
        w_got  <= 1'b1;
        wd_cap <= dp_wd;
        w_wait <= 0;
      end else if (w_valid) w_wait <= w_wait + 1;
      if (aw_got && w_got && !b_pend) begin
        mem[wa_cap] <= wd_cap;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
        b_err  <= (wr_total == err_at);
        wr_log[wr_total[5:0]] <= wa_cap;
      end
      if (b_valid && b_ready) begin
        b_pend   <= 1'b0;
        wr_total <= wr_total + 1;
      end
    end
  end

  // Mid-cycle monitor: done pulses, request activity and valid-held-until-ready violations.
  int   done_total = 0, ar_total = 0, aw_total = 0, viol = 0;
  logic ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;
  always @(negedge clk) begin
    if (done) done_total++;
    if (ar_valid) ar_total++;
    if (aw_valid) aw_total++;
    if (rst_n && ((ar_hold && !ar_valid) || (aw_hold && !aw_valid) || (w_hold && !w_valid))) viol++;
    ar_hold = rst_n && ar_valid && !ar_ready;
    aw_hold = rst_n && aw_valid && !aw_ready;
    w_hold  = rst_n && w_valid && !w_ready;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [7:0] a0, a1, a2, a3);
    init_mem[0] = a0; init_mem[1] = a1; init_mem[2] = a2; init_mem[3] = a3;
    for (int k = 4; k < 8; k++) init_mem[k] = 8'h00;
    arr_size = 4;
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
  endtask

  task automatic start_sort();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, err, sl_i, ld_i, sl_j, ld_j, ld_e2i, ld_e2c, sl_ra, ld_ra, ld_rd,
                sl_wa, ld_wa, sl_wd, ld_wd, ar_valid, r_ready, aw_valid, w_valid, b_ready});
  endfunction

  function automatic logic [31:0] mem4();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction

  int n, base_wr, base_done, base_ar, base_aw, rises;
  logic rr_prev;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 8; k++) init_mem[k] = 8'h00;
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", all_outs(), 32'd0);

    // Reverse-ish input, zero-wait memory.
    load4(8'd3, 8'd1, 8'd2, 8'd0);
    base_wr = wr_total; base_done = done_total;
    start_sort();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(3000, n);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    tick();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_mem", mem4(), 32'h03020100);
    check("t1_writes", 32'(wr_total - base_wr), 32'd8);
    check("t1_done_count", 32'(done_total - base_done), 32'd1);

    // One-element and empty arrays: no memory traffic, done three cycles after start.
    arr_size = 1;
    base_ar = ar_total; base_aw = aw_total;
    start_sort();
    wait_done(20, n);
    check("t2_latency_1", 32'(n + 1), 32'd3);
    arr_size = 0;
    tick();
    start_sort();
    wait_done(20, n);
    check("t2_latency_0", 32'(n + 1), 32'd3);
    tick();
    check("t2_no_ar", 32'(ar_total - base_ar), 32'd0);
    check("t2_no_aw", 32'(aw_total - base_aw), 32'd0);

    // Already sorted: only inserts, each landing at address i.
    load4(8'd0, 8'd1, 8'd2, 8'd3);
    base_wr = wr_total;
    start_sort();
    wait_done(3000, n);
    check("t3_done", 32'(done), 32'd1);
    tick();
    check("t3_writes", 32'(wr_total - base_wr), 32'd3);
    check("t3_addr0", 32'(wr_log[6'(base_wr)]), 32'd1);
    check("t3_addr1", 32'(wr_log[6'(base_wr + 1)]), 32'd2);
    check("t3_addr2", 32'(wr_log[6'(base_wr + 2)]), 32'd3);
    check("t3_mem", mem4(), 32'h03020100);

    // Back-pressure: random AR ready, W ready three cycles after valid while AW goes at once.
    bp_mode = 1'b1;
    load4(8'd2, 8'd3, 8'd0, 8'd1);
    base_wr = wr_total;
    start_sort();
    wait_done(6000, n);
    check("t4_done", 32'(done), 32'd1);
    tick();
    bp_mode = 1'b0;
    check("t4_mem", mem4(), 32'h03020100);
    check("t4_writes", 32'(wr_total - base_wr), 32'd7);
    check("t4_valid_stable", 32'(viol), 32'd0);

    // Error response on the second write: err sticks, sort still completes.
    load4(8'd3, 8'd1, 8'd2, 8'd0);
    base_wr = wr_total;
    err_at = wr_total + 1;
    start_sort();
    check("t5_err_start", 32'(err), 32'd0);
    wait_done(3000, n);
    check("t5_err_at_done", 32'(err), 32'd1);
    tick();
    err_at = -1;
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_mem", mem4(), 32'h03020100);
    check("t5_writes", 32'(wr_total - base_wr), 32'd8);
    load4(8'd0, 8'd1, 8'd2, 8'd3);
    check("t5_err_idle", 32'(err), 32'd1);
    start_sort();
    check("t5_err_cleared", 32'(err), 32'd0);
    wait_done(3000, n);
    tick();
    check("t5_err_clean", 32'(err), 32'd0);

    // Reset while waiting on the compare read, then a fresh sort.
    load4(8'd3, 8'd1, 8'd2, 8'd0);
    start_sort();
    rises = 0;
    rr_prev = 1'b0;
    for (int k = 0; k < 200 && rises < 2; k++) begin
      tick();
      if (r_ready && !rr_prev) rises++;
      rr_prev = r_ready;
    end
    check("t6_reach_cmp_r", 32'(rises), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", all_outs(), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load4(8'd2, 8'd0, 8'd3, 8'd1);
    start_sort();
    wait_done(3000, n);
    check("t6_done", 32'(done), 32'd1);
    tick();
    check("t6_mem", mem4(), 32'h03020100);
    check("t6_err", 32'(err), 32'd0);
    check("final_valid_stable", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
